fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one single-clock 8-bit FIFO between N_REQ producers.
- Grants one producer at a time, holds the grant for a bounded burst, and muxes the winner's data onto the FIFO write port.
- Back-pressure comes from the FIFO's registered full flag.
- Sits directly in front of the FIFO write port (wr, buf_in, full).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width; matches the FIFO word width.
- MAX_BURST, 8, maximum accepted beats per grant (1..64).

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester request/valid; bit i high means requester i has a beat on din.
- din  input  N_REQ*DW  flattened data; requester i at din[i*DW +: DW].
- fifo_full  input  1  FIFO full flag (registered in the FIFO).
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
- fifo_wr  output  1  FIFO write strobe, combinational.
- fifo_din  output  DW  FIFO write data, combinational mux of the granted requester.
- owner  output  clog2(N_REQ)  index of the granted requester; valid when busy=1.
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, owner=0, busy=0, beat_cnt=0, rr_ptr=0 (requester 0 has highest priority first).
- Reset combinational outputs: fifo_wr=0 because gnt=0; fifo_din=din[0 +: DW] (don't-care).
- Accept: beat accepted in a cycle iff gnt[owner] & req[owner] & ~fifo_full.
  - fifo_wr = accept; fifo_din = din[owner*DW +: DW].
  - FIFO samples at the same edge: zero-cycle latency, no extra buffering.
  - The arbiter never raises fifo_wr while fifo_full=1.
- Pick function: first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
- IDLE:
  - If req != 0, next state=GRANT, gnt=onehot(pick), owner=pick, beat_cnt=0.
  - Otherwise stay IDLE.
  - The first grant appears one cycle after req rises (1-cycle arbitration latency).
- GRANT, release conditions evaluated at each edge:
  - (a) req[owner]=0, or
  - (b) accept & beat_cnt==MAX_BURST-1.
- GRANT, on release:
  - rr_ptr=(owner+1) mod N_REQ.
  - Re-pick from the current cycle's req vector with the new rr_ptr; the old owner is naturally last.
  - Under (b) the old owner's req is still high; it is re-granted only if no other requester is asserting.
  - If the pick finds a requester, go directly to GRANT with the new owner and beat_cnt=0 (no idle bubble).
  - Otherwise go to IDLE with gnt=0.
- GRANT, no release: beat_cnt increments on accept; hold while stalled.
- fifo_full stall: grant held, beat_cnt frozen, no timeout, no preemption.
- req[owner] dropped in a cycle: no write that cycle; release at that edge.
- MAX_BURST=1: every accepted beat releases; pure per-beat round-robin.
- Width rules:
  - beat_cnt is clog2(MAX_BURST)+1 bits.
  - rr_ptr and owner wrap modulo N_REQ, including non-power-of-2 N_REQ.
- Invariant: gnt is zero or one-hot at all times.
- Reset mid-burst: grant dropped immediately. A beat being accepted when reset asserts must not be written; fifo_wr falls with gnt.

Decomposition:
- Package fifo_arb_pkg:
  - State enum {IDLE, GRANT}.
  - Function clog2.
  - Function onehot(idx, n).
- Sub-module rr_pick: combinational rotating priority finder.
  - Inputs: req, rr_ptr.
  - Outputs: found, idx.
  - Instantiated once.

Test Plan:
- Reset, then req=4'b0100 with din[2]=8'hA5 and fifo_full=0.
  - Cycle after req: gnt=4'b0100, owner=2.
  - Following cycles: fifo_wr=1, fifo_din=8'hA5.
- req=4'b1111 held, fifo never full, MAX_BURST=8.
  - Grants run 0,1,2,3,0, each for exactly 8 writes.
  - No idle cycle between owners; 40 writes total in 40 grant cycles.
- Owner 1 bursting, fifo_full=1 for 5 cycles after beat 3.
  - fifo_wr=0 during the stall; gnt stays 4'b0010 and beat_cnt stays 3.
  - After full drops, exactly 5 more beats (8 total), then release.
- Only req[3] active, MAX_BURST=8, 20 beats.
  - Requester 3 is re-granted back-to-back after each 8-beat burst.
  - 20 contiguous writes, gnt never 0.
- Owner 0 drops req after 2 beats while req[2]=1.
  - At that edge gnt goes to 4'b0100.
  - Exactly 2 writes from requester 0, then 2's data follows.
- Assert rst mid-burst on beat 4.
  - gnt=0 and fifo_wr=0 immediately.
  - After release with req=4'b0011, first grant goes to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and elaboration-time helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int MAX_REQ = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Bits at or above n stay clear so the caller can slice to its own width.
   function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
      logic [MAX_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         v[i] = (i == idx) && (i < n);
      end
      return v;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority finder: first asserted request at or after rr_ptr_i, modulo N_REQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int OW    = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [OW-1:0]    rr_ptr_i,
   output logic             found_o,
   output logic [OW-1:0]    idx_o
);

   logic [OW:0]   cand;
   logic [OW-1:0] sel;

   // One extra bit on cand keeps rr_ptr_i + k from overflowing before the wrap.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      sel     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_i} + (OW+1)'(k);
         if (cand >= (OW+1)'(N_REQ)) cand = cand - (OW+1)'(N_REQ);
         sel = cand[OW-1:0];
         if (!found_o && req_i[sel]) begin
            found_o = 1'b1;
            idx_o   = sel;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// holding each grant for up to MAX_BURST accepted beats; full stalls without releasing.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DW-1:0]      din,
   input  logic                     fifo_full,
   output logic [N_REQ-1:0]         gnt,
   output logic                     fifo_wr,
   output logic [DW-1:0]            fifo_din,
   output logic [clog2(N_REQ)-1:0]  owner,
   output logic                     busy
);

   localparam int OW = clog2(N_REQ);
   localparam int CW = clog2(MAX_BURST) + 1;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

   logic [OW-1:0]      next_ptr;
   logic [OW-1:0]      pick_ptr;
   logic               pick_found;
   logic [OW-1:0]      pick_idx;
   logic [MAX_REQ-1:0] pick_oh;
   logic               accept;
   logic               last_beat;
   logic               release_grant;

   assign next_ptr = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
   // On release the search starts just past the old owner, so it is naturally last.
   assign pick_ptr = (state_q == GRANT) ? next_ptr : rr_ptr_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .OW    (OW)
   ) u_pick (
      .req_i    (req),
      .rr_ptr_i (pick_ptr),
      .found_o  (pick_found),
      .idx_o    (pick_idx)
   );

   assign pick_oh       = onehot(int'(pick_idx), N_REQ);
   assign accept        = gnt_q[owner_q] & req[owner_q] & ~fifo_full;
   assign last_beat     = (beat_cnt_q == CW'(MAX_BURST - 1));
   assign release_grant = ~req[owner_q] | (accept & last_beat);

   assign fifo_wr  = accept;
   assign fifo_din = din[owner_q*DW +: DW];
   assign gnt      = gnt_q;
   assign owner    = owner_q;
   assign busy     = (state_q == GRANT);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = GRANT;
               gnt_d      = pick_oh[N_REQ-1:0];
               owner_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (release_grant) begin
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
               if (pick_found) begin
                  gnt_d   = pick_oh[N_REQ-1:0];
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] din;
   logic            fifo_full;
   logic [N-1:0]    gnt;
   logic            fifo_wr;
   logic [DW-1:0]   fifo_din;
   logic [1:0]      owner;
   logic            busy;

   int total;
   int bad;

   fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din       (din),
      .fifo_full (fifo_full),
      .gnt       (gnt),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .owner     (owner),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      fifo_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req       = '0;
      fifo_full = 1'b0;
      din       = 32'h44332211;
      @(negedge clk);
      #1;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
      total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", fifo_wr); end
      total++; if (fifo_din !== 8'h11) begin bad++; $display("FAIL reset_din got=%h want=11", fifo_din); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      din = 32'h00A50000;
      req = 4'b0100;
      #1;
      total++; if (gnt !== 4'b0000 || fifo_wr !== 1'b0) begin bad++; $display("FAIL single_latency gnt=%b wr=%b want gnt=0000 wr=0", gnt, fifo_wr); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         total++;
         if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1 || fifo_wr !== 1'b1 || fifo_din !== 8'hA5) begin
            bad++;
            $display("FAIL single_beat%0d gnt=%b owner=%0d busy=%b wr=%b din=%h want 0100/2/1/1/a5", k, gnt, owner, busy, fifo_wr, fifo_din);
         end
      end
      @(negedge clk); req = 4'b0000; #1;
      total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL single_drop_wr got=%b want=0", fifo_wr); end
      @(negedge clk); #1;
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_idle gnt=%b busy=%b want 0000/0", gnt, busy); end
   endtask

   task automatic test_round_robin();
      int exp_o;
      int wcnt;
      do_reset();
      din  = 32'h33221100;
      req  = 4'b1111;
      wcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         exp_o = (k / 8) % 4;
         if (fifo_wr === 1'b1) wcnt++;
         total++;
         if (gnt !== 4'(1 << exp_o) || fifo_wr !== 1'b1 || fifo_din !== 8'(exp_o * 8'h11)) begin
            bad++;
            $display("FAIL rr_cycle%0d gnt=%b wr=%b din=%h want owner %0d writing", k, gnt, fifo_wr, fifo_din, exp_o);
         end
      end
      total++; if (wcnt !== 40) begin bad++; $display("FAIL rr_writes got=%0d want=40", wcnt); end
      @(negedge clk); req = 4'b0000;
   endtask

   task automatic test_stall();
      int wcnt;
      do_reset();
      din  = 32'h00001100;
      req  = 4'b0010;
      wcnt = 0;
      @(negedge clk); req = 4'b0011; #1;
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_grant got=%b want=0010", gnt); end
      if (fifo_wr === 1'b1) wcnt++;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         if (fifo_wr === 1'b1) wcnt++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); fifo_full = 1'b1; #1;
         total++;
         if (fifo_wr !== 1'b0 || gnt !== 4'b0010 || dut.beat_cnt_q !== 4'd3) begin
            bad++;
            $display("FAIL stall_cycle%0d wr=%b gnt=%b cnt=%0d want 0/0010/3", k, fifo_wr, gnt, dut.beat_cnt_q);
         end
      end
      @(negedge clk); fifo_full = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (fifo_wr === 1'b1) wcnt++;
         total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_resume%0d gnt=%b want=0010", k, gnt); end
      end
      total++; if (wcnt !== 8) begin bad++; $display("FAIL stall_writes got=%0d want=8", wcnt); end
      @(negedge clk); #1;
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL stall_release gnt=%b want=0001", gnt); end
      req = 4'b0000;
   endtask

   task automatic test_back_to_back();
      int wcnt;
      do_reset();
      din  = 32'h77000000;
      req  = 4'b1000;
      wcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (fifo_wr === 1'b1) wcnt++;
         total++;
         if (gnt !== 4'b1000 || fifo_wr !== 1'b1 || fifo_din !== 8'h77) begin
            bad++;
            $display("FAIL b2b_cycle%0d gnt=%b wr=%b din=%h want 1000/1/77", k, gnt, fifo_wr, fifo_din);
         end
      end
      total++; if (wcnt !== 20) begin bad++; $display("FAIL b2b_writes got=%0d want=20", wcnt); end
      @(negedge clk); req = 4'b0000;
   endtask

   task automatic test_drop();
      int wcnt;
      do_reset();
      din  = 32'h002B000A;
      req  = 4'b0101;
      wcnt = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         if (fifo_wr === 1'b1 && fifo_din === 8'h0A) wcnt++;
      end
      total++; if (wcnt !== 2) begin bad++; $display("FAIL drop_writes0 got=%0d want=2", wcnt); end
      @(negedge clk); req = 4'b0100; #1;
      total++; if (fifo_wr !== 1'b0 || gnt !== 4'b0001) begin bad++; $display("FAIL drop_cycle wr=%b gnt=%b want 0/0001", fifo_wr, gnt); end
      @(negedge clk); #1;
      total++;
      if (gnt !== 4'b0100 || fifo_wr !== 1'b1 || fifo_din !== 8'h2B) begin
         bad++;
         $display("FAIL drop_handover gnt=%b wr=%b din=%h want 0100/1/2b", gnt, fifo_wr, fifo_din);
      end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      din = 32'h00002211;
      req = 4'b0001;
      // Dropping req[0] releases the grant and moves the pointer past requester 0.
      @(negedge clk); req = 4'b0010;
      for (int k = 0; k < 4; k++) @(negedge clk);
      #1;
      total++; if (fifo_wr !== 1'b1 || gnt !== 4'b0010) begin bad++; $display("FAIL mid_pre wr=%b gnt=%b want 1/0010", fifo_wr, gnt); end
      rst = 1'b1;
      #1;
      total++; if (gnt !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst gnt=%b wr=%b busy=%b want 0000/0/0", gnt, fifo_wr, busy); end
      @(negedge clk); rst = 1'b0; req = 4'b0011;
      @(negedge clk); #1;
      total++; if (gnt !== 4'b0001 || owner !== 2'd0) begin bad++; $display("FAIL mid_regrant gnt=%b owner=%0d want 0001/0", gnt, owner); end
      req = 4'b0000;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req       = '0;
      din       = '0;
      fifo_full = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
